// File: rtl/matrix_framebuf.sv
// Multi-bank LED-matrix frame buffer: writer owns the back bank, scanner reads the front bank,
// swaps commit on frame_end. Optional MATRIXFB_CLEAR_EN zeroes the new back bank after each commit.
module matrix_framebuf #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int NUM_BANKS = 2,
  parameter int BE_W      = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_chipselect,
  input  logic              wr_write,
  input  logic [DATA_W-1:0] wr_writedata,
  input  logic [BE_W-1:0]   wr_byteenable,
  output logic [DATA_W-1:0] wr_readdata,
  output logic              wr_waitrequest,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_clken,
  output logic [DATA_W-1:0] rd_readdata,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_pending,
  output logic [1:0]        front_bank
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = ADDR_W + BANK_W;
  localparam int WORDS  = NUM_BANKS * (1 << ADDR_W);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [BANK_W-1:0] front_q, front_d, back_bank;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] wr_rdata_q, rd_rdata_q;
  logic              wr_access, swap_ok, commit;

  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem [WORDS];

  assign back_bank    = (front_q == LAST_BANK) ? '0 : front_q + BANK_W'(1);
  assign wr_access    = wr_chipselect & ~wr_waitrequest;
  assign commit       = frame_end & (pending_q | swap_req) & swap_ok;
  assign front_bank   = 2'(front_q);
  assign swap_pending = pending_q;
  assign wr_readdata  = wr_rdata_q;
  assign rd_readdata  = rd_rdata_q;

`ifdef MATRIXFB_CLEAR_EN
  // state    | meaning
  // ST_IDLE  | writer has the back bank, swaps may commit
  // ST_CLEAR | zeroing the new back bank one word per cycle, writer stalled
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_active;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = '0;
    case (state_q)
      ST_IDLE:  if (commit) state_d = ST_CLEAR;
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_active     = (state_q == ST_CLEAR);
    wr_waitrequest = clr_active;
    swap_ok        = ~clr_active;
  end
`else
  assign wr_waitrequest = 1'b0;
  assign swap_ok        = 1'b1;
`endif

  always_comb begin
    front_d   = front_q;
    pending_d = pending_q;
    if (commit) begin
      front_d   = back_bank;
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      front_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      front_q   <= front_d;
      pending_q <= pending_d;
    end
  end

  // Clear traffic borrows the writer port; the writer is stalled while it runs.
  always_comb begin
    mem_we    = wr_access & wr_write;
    mem_be    = wr_byteenable;
    mem_wdata = wr_writedata;
    mem_waddr = {back_bank, wr_address};
`ifdef MATRIXFB_CLEAR_EN
    if (clr_active) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_wdata = '0;
      mem_waddr = {back_bank, clr_addr_q};
    end
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Bank index is taken from the request cycle, so a same-cycle swap cannot redirect data in flight.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_rdata_q <= '0;
      rd_rdata_q <= '0;
    end else begin
      if (wr_access && !wr_write) wr_rdata_q <= mem[{back_bank, wr_address}];
      if (rd_clken)               rd_rdata_q <= mem[{front_q, rd_address}];
    end
  end

endmodule

// File: tb/tb_matrix_framebuf.sv
// Self-checking bench for matrix_framebuf (3 banks x 16 words) against an array-based reference model.
module tb_matrix_framebuf;
  localparam int DW = 32, AW = 4, NB = 3, BEW = 4, DEPTH = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic [AW-1:0] wr_address = '0;
  logic          wr_chipselect = 1'b0;
  logic          wr_write = 1'b0;
  logic [DW-1:0] wr_writedata = '0;
  logic [BEW-1:0] wr_byteenable = '0;
  logic [DW-1:0] wr_readdata;
  logic          wr_waitrequest;
  logic [AW-1:0] rd_address = '0;
  logic          rd_clken = 1'b0;
  logic [DW-1:0] rd_readdata;
  logic          swap_req = 1'b0;
  logic          frame_end = 1'b0;
  logic          swap_pending;
  logic [1:0]    front_bank;

  matrix_framebuf #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .wr_address(wr_address), .wr_chipselect(wr_chipselect), .wr_write(wr_write),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable), .wr_readdata(wr_readdata),
    .wr_waitrequest(wr_waitrequest), .rd_address(rd_address), .rd_clken(rd_clken),
    .rd_readdata(rd_readdata), .swap_req(swap_req), .frame_end(frame_end),
    .swap_pending(swap_pending), .front_bank(front_bank)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NB][DEPTH];
  bit            m_known [NB][DEPTH];
  int            m_front = 0;
  bit            m_pend = 0;
  logic [DW-1:0] m_wr = '0, m_rd = '0;
  bit            m_wr_known = 1, m_rd_known = 1;
  int            m_clear_left = 0;
  bit            m_accepted = 0;

  function automatic void model_step();
    int f, b;
    bit in_clear, commit;
    logic [DW-1:0] w;
    if (reset_reset) begin
      m_front = 0; m_pend = 0; m_wr = '0; m_rd = '0;
      m_wr_known = 1; m_rd_known = 1; m_clear_left = 0; m_accepted = 0;
      return;
    end
    f = m_front;
    b = (f + 1) % NB;
    in_clear = (m_clear_left > 0);
    m_accepted = wr_chipselect && !in_clear;
    if (m_accepted && !wr_write) begin
      m_wr = m_mem[b][wr_address]; m_wr_known = m_known[b][wr_address];
    end
    if (rd_clken) begin
      m_rd = m_mem[f][rd_address]; m_rd_known = m_known[f][rd_address];
    end
    if (m_accepted && wr_write) begin
      w = m_mem[b][wr_address];
      for (int i = 0; i < BEW; i++) if (wr_byteenable[i]) w[8*i +: 8] = wr_writedata[8*i +: 8];
      m_mem[b][wr_address] = w;
      m_known[b][wr_address] = m_known[b][wr_address] || (wr_byteenable == 4'hF);
    end
    if (in_clear) begin
      m_mem[b][DEPTH - m_clear_left] = '0;
      m_known[b][DEPTH - m_clear_left] = 1;
      m_clear_left--;
    end
    commit = frame_end && (m_pend || swap_req) && !in_clear;
    if (commit) begin
      m_front = b;
      m_pend = 0;
`ifdef MATRIXFB_CLEAR_EN
      m_clear_left = DEPTH;
`endif
    end else if (swap_req) begin
      m_pend = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_chipselect = 0; wr_write = 0; rd_clken = 0; swap_req = 0; frame_end = 0;
  endtask

  task automatic wait_clear();
    for (int n = 0; n < DEPTH + 4 && m_clear_left > 0; n++) tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    wr_address = a; wr_writedata = d; wr_byteenable = be; wr_write = 1; wr_chipselect = 1;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (m_accepted) break;
    end
    wr_chipselect = 0; wr_write = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    wr_address = a; wr_write = 0; wr_chipselect = 1;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (m_accepted) break;
    end
    wr_chipselect = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_reset = 1;
    tick(); tick();
    total++; if (front_bank !== 2'd0) begin bad++; $display("FAIL reset_front: got %0d want 0", front_bank); end
    total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
    total++; if (wr_readdata !== 32'h0) begin bad++; $display("FAIL reset_wr_readdata: got %h want 0", wr_readdata); end
    total++; if (rd_readdata !== 32'h0) begin bad++; $display("FAIL reset_rd_readdata: got %h want 0", rd_readdata); end
    total++; if (wr_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_waitrequest: got %b want 0", wr_waitrequest); end
    reset_reset = 0;
    tick();
  endtask

  // Fill every bank with known data by writing the back bank and rotating through all banks.
  task automatic prefill();
    for (int k = 0; k < NB; k++) begin
      wait_clear();
      for (int a = 0; a < DEPTH; a++) do_write(AW'(a), $urandom, 4'hF);
      swap_req = 1; frame_end = 1; tick(); swap_req = 0; frame_end = 0;
    end
    wait_clear();
    total++; if (front_bank !== 2'(m_front)) begin bad++; $display("FAIL prefill_front: got %0d want %0d", front_bank, m_front); end
  endtask

  task automatic test_writer_rw();
    do_write(5, 32'hDEADBEEF, 4'hF);
    do_read(5);
    total++; if (wr_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_readback: got %h want deadbeef", wr_readdata); end
    rd_address = 5; rd_clken = 1; tick(); rd_clken = 0;
    total++; if (rd_readdata === 32'hDEADBEEF) begin bad++; $display("FAIL rd_not_back: got %h want front-bank data", rd_readdata); end
    total++; if (rd_readdata !== m_rd) begin bad++; $display("FAIL rd_front_data: got %h want %h", rd_readdata, m_rd); end
  endtask

  task automatic test_byteenable();
    logic [DW-1:0] d;
    do_write(7, 32'hFFFFFFFF, 4'hF);
    do_write(7, 32'h000000AA, 4'h1);
    do_read(7);
    total++; if (wr_readdata !== 32'hFFFFFFAA) begin bad++; $display("FAIL byteenable_low: got %h want ffffffaa", wr_readdata); end
    d = $urandom;
    do_write(8, 32'h12345678, 4'hF);
    do_write(8, d, 4'b0110);
    do_read(8);
    total++; if (wr_readdata !== {8'h12, d[23:8], 8'h78}) begin bad++; $display("FAIL byteenable_mid: got %h want %h", wr_readdata, {8'h12, d[23:8], 8'h78}); end
  endtask

  task automatic test_swap();
    int f0;
    wait_clear();
    f0 = m_front;
    do_write(5, 32'h11223344, 4'hF);
    swap_req = 1; tick(); swap_req = 0;
    total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL swap_pending_set: got %b want 1", swap_pending); end
    repeat (9) tick();
    total++; if (front_bank !== 2'(f0)) begin bad++; $display("FAIL swap_no_early_commit: got %0d want %0d", front_bank, f0); end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (front_bank !== 2'((f0 + 1) % NB)) begin bad++; $display("FAIL swap_commit_front: got %0d want %0d", front_bank, (f0 + 1) % NB); end
    total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL swap_commit_pending: got %b want 0", swap_pending); end
    rd_address = 5; rd_clken = 1; tick(); rd_clken = 0;
    total++; if (rd_readdata !== 32'h11223344) begin bad++; $display("FAIL swap_visible: got %h want 11223344", rd_readdata); end
    rd_address = 6; tick();
    total++; if (rd_readdata !== 32'h11223344) begin bad++; $display("FAIL rd_hold: got %h want 11223344", rd_readdata); end
    wait_clear();
  endtask

  task automatic test_reset_pending();
    wait_clear();
    if (m_front == 0) begin
      swap_req = 1; frame_end = 1; tick(); swap_req = 0; frame_end = 0;
      wait_clear();
    end
    swap_req = 1; tick(); swap_req = 0;
    total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL pend_before_reset: got %b want 1", swap_pending); end
    reset_reset = 1; tick(); reset_reset = 0;
    total++; if (front_bank !== 2'd0) begin bad++; $display("FAIL reset_pend_front: got %0d want 0", front_bank); end
    total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL reset_pend_pending: got %b want 0", swap_pending); end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (front_bank !== 2'd0) begin bad++; $display("FAIL frame_end_no_req: got %0d want 0", front_bank); end
  endtask

  task automatic test_same_cycle();
    for (int k = 1; k <= 3; k++) begin
      wait_clear();
      swap_req = 1; frame_end = 1; tick(); swap_req = 0; frame_end = 0;
      total++; if (front_bank !== 2'(k % NB)) begin bad++; $display("FAIL same_cycle_front%0d: got %0d want %0d", k, front_bank, k % NB); end
      total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL same_cycle_pending%0d: got %b want 0", k, swap_pending); end
      tick();
      total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL same_cycle_pending_after%0d: got %b want 0", k, swap_pending); end
    end
  endtask

`ifdef MATRIXFB_CLEAR_EN
  task automatic test_clear();
    int f0, cnt;
    wait_clear();
    f0 = m_front;
    swap_req = 1; frame_end = 1; tick(); swap_req = 0; frame_end = 0;
    cnt = 0;
    while (wr_waitrequest === 1'b1 && cnt < 40) begin
      frame_end = (cnt == 3);
      swap_req = (cnt == 5);
      tick();
      cnt++;
    end
    frame_end = 0; swap_req = 0;
    total++; if (cnt !== DEPTH) begin bad++; $display("FAIL clear_wait_cycles: got %0d want %0d", cnt, DEPTH); end
    total++; if (front_bank !== 2'((f0 + 1) % NB)) begin bad++; $display("FAIL clear_no_swap: got %0d want %0d", front_bank, (f0 + 1) % NB); end
    total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL clear_req_pending: got %b want 1", swap_pending); end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a));
      total++; if (wr_readdata !== 32'h0) begin bad++; $display("FAIL clear_zero[%0d]: got %h want 0", a, wr_readdata); end
    end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (front_bank !== 2'((f0 + 2) % NB)) begin bad++; $display("FAIL clear_commit_after: got %0d want %0d", front_bank, (f0 + 2) % NB); end
    repeat (3) tick();
    reset_reset = 1; tick(); reset_reset = 0;
    total++; if (wr_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_mid_clear: got %b want 0", wr_waitrequest); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_chipselect = ($urandom_range(0, 2) != 0);
      wr_write      = $urandom_range(0, 1);
      wr_address    = AW'($urandom_range(0, DEPTH - 1));
      wr_writedata  = $urandom;
      wr_byteenable = ($urandom_range(0, 3) == 0) ? BEW'($urandom) : 4'hF;
      rd_address    = AW'($urandom_range(0, DEPTH - 1));
      rd_clken      = $urandom_range(0, 1);
      swap_req      = ($urandom_range(0, 7) == 0);
      frame_end     = ($urandom_range(0, 9) == 0);
      tick();
      total++; if (front_bank !== 2'(m_front)) begin bad++; $display("FAIL rand_front@%0d: got %0d want %0d", n, front_bank, m_front); end
      total++; if (swap_pending !== m_pend) begin bad++; $display("FAIL rand_pending@%0d: got %b want %b", n, swap_pending, m_pend); end
      total++; if (wr_waitrequest !== (m_clear_left > 0)) begin bad++; $display("FAIL rand_wait@%0d: got %b want %b", n, wr_waitrequest, m_clear_left > 0); end
      if (m_wr_known) begin
        total++; if (wr_readdata !== m_wr) begin bad++; $display("FAIL rand_wr_readdata@%0d: got %h want %h", n, wr_readdata, m_wr); end
      end
      if (m_rd_known) begin
        total++; if (rd_readdata !== m_rd) begin bad++; $display("FAIL rand_rd_readdata@%0d: got %h want %h", n, rd_readdata, m_rd); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        m_mem[b][a] = '0;
        m_known[b][a] = 0;
      end
    test_reset();
    prefill();
    test_writer_rw();
    test_byteenable();
    test_swap();
    test_reset_pending();
    test_same_cycle();
`ifdef MATRIXFB_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
